// File: rtl/axis_downsizer.sv
// AXI-stream width downsizer: splits each IN_W-bit beat into RATIO narrow
// OUT_W-bit beats, least significant sub-word first, optionally skipping
// sub-words whose byte enables are all clear.
`timescale 1ns/1ps
module axis_downsizer #(
    parameter int OUT_W      = 512,
    parameter int RATIO      = 2,
    parameter int DROP_EMPTY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [OUT_W*RATIO-1:0]    in_data,
    input  logic [OUT_W*RATIO/8-1:0]  in_keep,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [OUT_W/8-1:0]        out_keep,
    output logic                      out_valid,
    output logic                      out_last,
    input  logic                      out_ready,
    output logic [31:0]               stat_in_beats,
    output logic [31:0]               stat_out_beats
);

    localparam int IN_W  = OUT_W * RATIO;
    localparam int KW    = OUT_W / 8;
    localparam int IN_KW = IN_W / 8;
    localparam int IDX_W = $clog2(RATIO);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // One bit per sub-word: set when that sub-word has at least one byte enabled.
    function automatic logic [RATIO-1:0] slice_nonzero(input logic [IN_KW-1:0] keep);
        logic [RATIO-1:0] nz;
        nz = {RATIO{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            nz[i] = |keep[i*KW +: KW];
        end
        return nz;
    endfunction

    // Lowest set sub-word index at or above 'from'; zero when none is set.
    function automatic logic [IDX_W-1:0] first_set_from(input logic [RATIO-1:0] nz, input int from);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (nz[i] && (i >= from)) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    // Highest set sub-word index; zero when none is set.
    function automatic logic [IDX_W-1:0] highest_set(input logic [RATIO-1:0] nz);
        logic [IDX_W-1:0] r;
        r = {IDX_W{1'b0}};
        for (int i = 0; i < RATIO; i++) begin
            if (nz[i]) begin
                r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    state_t             state_r, state_n;
    logic [IN_W-1:0]    data_r, data_n;
    logic [IN_KW-1:0]   keep_r, keep_n;
    logic               last_r, last_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [IDX_W-1:0]   fin_r, fin_n;
    logic               run_r;
    logic [OUT_W-1:0]   out_data_r, out_data_n;
    logic [KW-1:0]      out_keep_r, out_keep_n;
    logic               out_valid_r, out_valid_n;
    logic               out_last_r, out_last_n;
    logic [31:0]        stat_in_r, stat_out_r;

    logic [RATIO-1:0]   in_nz_s, held_nz_s;
    logic               load_skip_s;
    logic [IDX_W-1:0]   load_idx_s, load_fin_s, adv_idx_s;
    logic               is_final_s, in_ready_s, in_xfer_s, out_xfer_s;
    logic               load_s, drop_s, finish_s, advance_s, to_idle_s;

    // Sub-word selection for a newly arriving beat and for stepping the held beat.
    always_comb begin
        in_nz_s   = slice_nonzero(in_keep);
        held_nz_s = slice_nonzero(keep_r);
        if (DROP_EMPTY != 0) begin
            load_skip_s = (in_nz_s == {RATIO{1'b0}}) && !in_last;
            load_idx_s  = first_set_from(in_nz_s, 0);
            load_fin_s  = highest_set(in_nz_s);
            adv_idx_s   = first_set_from(held_nz_s, int'(idx_r) + 1);
        end else begin
            load_skip_s = 1'b0;
            load_idx_s  = {IDX_W{1'b0}};
            load_fin_s  = IDX_W'(RATIO - 1);
            adv_idx_s   = idx_r + IDX_W'(1);
        end
    end

    // Handshake decode; in_ready only looks at registered state and out_ready.
    always_comb begin
        is_final_s = (idx_r == fin_r);
        if (state_r == ST_IDLE) begin
            in_ready_s = run_r;
        end else begin
            in_ready_s = run_r && is_final_s && out_ready;
        end
        in_xfer_s  = in_valid && in_ready_s;
        out_xfer_s = out_valid_r && out_ready;
        load_s     = in_xfer_s && !load_skip_s;
        drop_s     = in_xfer_s && load_skip_s;
        finish_s   = (state_r == ST_SEND) && out_xfer_s && is_final_s && !in_xfer_s;
        advance_s  = (state_r == ST_SEND) && out_xfer_s && !is_final_s;
        to_idle_s  = drop_s || finish_s;
    end

    // Next-state logic of the IDLE/SEND controller.
    always_comb begin
        state_n = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_s) begin
                    state_n = ST_SEND;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (load_s || !to_idle_s) begin
                    state_n = ST_SEND;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Held-beat and output register next values: clear, load, step or hold.
    always_comb begin
        data_n      = data_r;
        keep_n      = keep_r;
        last_n      = last_r;
        idx_n       = idx_r;
        fin_n       = fin_r;
        out_data_n  = out_data_r;
        out_keep_n  = out_keep_r;
        out_valid_n = out_valid_r;
        out_last_n  = out_last_r;
        if (load_s) begin
            data_n      = in_data;
            keep_n      = in_keep;
            last_n      = in_last;
            idx_n       = load_idx_s;
            fin_n       = load_fin_s;
            out_valid_n = 1'b1;
            out_data_n  = in_data[int'(load_idx_s)*OUT_W +: OUT_W];
            out_keep_n  = in_keep[int'(load_idx_s)*KW +: KW];
            out_last_n  = in_last && (load_idx_s == load_fin_s);
        end else if (to_idle_s) begin
            idx_n       = {IDX_W{1'b0}};
            out_valid_n = 1'b0;
            out_last_n  = 1'b0;
            out_data_n  = {OUT_W{1'b0}};
            out_keep_n  = {KW{1'b0}};
        end else if (advance_s) begin
            idx_n       = adv_idx_s;
            out_data_n  = data_r[int'(adv_idx_s)*OUT_W +: OUT_W];
            out_keep_n  = keep_r[int'(adv_idx_s)*KW +: KW];
            out_last_n  = last_r && (adv_idx_s == fin_r);
        end else begin
            // no transfer: beat, index and outputs stay put
            idx_n       = idx_r;
            out_valid_n = out_valid_r;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Held beat and registered output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r      <= {IN_W{1'b0}};
            keep_r      <= {IN_KW{1'b0}};
            last_r      <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            fin_r       <= {IDX_W{1'b0}};
            out_data_r  <= {OUT_W{1'b0}};
            out_keep_r  <= {KW{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            data_r      <= data_n;
            keep_r      <= keep_n;
            last_r      <= last_n;
            idx_r       <= idx_n;
            fin_r       <= fin_n;
            out_data_r  <= out_data_n;
            out_keep_r  <= out_keep_n;
            out_valid_r <= out_valid_n;
            out_last_r  <= out_last_n;
        end
    end

    // Holds in_ready low during reset and releases it on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
        end
    end

    // Accepted-beat counters on both channels, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_in_r  <= 32'd0;
            stat_out_r <= 32'd0;
        end else begin
            if (in_xfer_s) begin
                stat_in_r <= stat_in_r + 32'd1;
            end else begin
                stat_in_r <= stat_in_r;
            end
            if (out_xfer_s) begin
                stat_out_r <= stat_out_r + 32'd1;
            end else begin
                stat_out_r <= stat_out_r;
            end
        end
    end

    assign in_ready       = in_ready_s;
    assign out_data       = out_data_r;
    assign out_keep       = out_keep_r;
    assign out_valid      = out_valid_r;
    assign out_last       = out_last_r;
    assign stat_in_beats  = stat_in_r;
    assign stat_out_beats = stat_out_r;

endmodule

// File: tb/tb_axis_downsizer.sv
// Bench for axis_downsizer: two RATIO=4 instances (keep-drop off/on) share a
// random stream checked against a sub-word list model; a default-parameter
// instance covers the 2:1 back-to-back case.
`timescale 1ns/1ps
module tb_axis_downsizer;

    localparam int OW  = 32;
    localparam int R   = 4;
    localparam int IW  = OW * R;
    localparam int KW  = OW / 8;
    localparam int IKW = IW / 8;

    typedef struct {
        logic [OW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [IW-1:0]  in_data;
    logic [IKW-1:0] in_keep;
    logic           in_last;
    logic           in_valid_a  [2];
    logic           in_ready_a  [2];
    logic [OW-1:0]  out_data_a  [2];
    logic [KW-1:0]  out_keep_a  [2];
    logic           out_valid_a [2];
    logic           out_last_a  [2];
    logic           out_ready_a [2];
    logic [31:0]    stat_in_a   [2];
    logic [31:0]    stat_out_a  [2];

    logic [1023:0]  in_data2;
    logic [127:0]   in_keep2;
    logic           in_valid2, in_last2, in_ready2;
    logic [511:0]   out_data2;
    logic [63:0]    out_keep2;
    logic           out_valid2, out_last2, out_ready2;
    logic [31:0]    stat_in2, stat_out2;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_in  [2];
    int   exp_out [2];
    exp_t q [2][$];
    logic rmode;

    axis_downsizer #(.OUT_W(OW), .RATIO(R), .DROP_EMPTY(0)) u_keep_all (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_keep(in_keep),
        .in_valid(in_valid_a[0]), .in_last(in_last), .in_ready(in_ready_a[0]),
        .out_data(out_data_a[0]), .out_keep(out_keep_a[0]), .out_valid(out_valid_a[0]),
        .out_last(out_last_a[0]), .out_ready(out_ready_a[0]),
        .stat_in_beats(stat_in_a[0]), .stat_out_beats(stat_out_a[0]));

    axis_downsizer #(.OUT_W(OW), .RATIO(R), .DROP_EMPTY(1)) u_drop (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_keep(in_keep),
        .in_valid(in_valid_a[1]), .in_last(in_last), .in_ready(in_ready_a[1]),
        .out_data(out_data_a[1]), .out_keep(out_keep_a[1]), .out_valid(out_valid_a[1]),
        .out_last(out_last_a[1]), .out_ready(out_ready_a[1]),
        .stat_in_beats(stat_in_a[1]), .stat_out_beats(stat_out_a[1]));

    axis_downsizer u_wide (
        .clk(clk), .rst_n(rst_n), .in_data(in_data2), .in_keep(in_keep2),
        .in_valid(in_valid2), .in_last(in_last2), .in_ready(in_ready2),
        .out_data(out_data2), .out_keep(out_keep2), .out_valid(out_valid2),
        .out_last(out_last2), .out_ready(out_ready2),
        .stat_in_beats(stat_in2), .stat_out_beats(stat_out2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: list the sub-words the spec says must appear, then mark the packet end.
    task automatic model_push(input int drop, input logic [IW-1:0] d, input logic [IKW-1:0] k, input logic l);
        exp_t beats[$];
        exp_t e;
        int   n;
        for (int s = 0; s < R; s++) begin
            e.d = d[s*OW +: OW];
            e.k = k[s*KW +: KW];
            e.l = 1'b0;
            if (drop == 0 || e.k != 4'h0) beats.push_back(e);
        end
        if (beats.size() == 0 && l) begin
            e.d = d[OW-1:0];
            e.k = 4'h0;
            e.l = 1'b1;
            beats.push_back(e);
        end
        n = beats.size();
        for (int i = 0; i < n; i++) begin
            e = beats[i];
            e.l = l && (i == n - 1);
            q[drop].push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rmode) begin
            out_ready_a[0] = 1'($urandom_range(0, 1));
            out_ready_a[1] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic [IKW-1:0] k, input logic l);
        logic t0, t1;
        int   n;
        in_data = d;
        in_keep = k;
        in_last = l;
        in_valid_a[0] = 1'b1;
        in_valid_a[1] = 1'b1;
        n = 0;
        while ((in_valid_a[0] || in_valid_a[1]) && n < 400) begin
            @(negedge clk);
            t0 = in_valid_a[0] && in_ready_a[0];
            t1 = in_valid_a[1] && in_ready_a[1];
            tick();
            if (t0) in_valid_a[0] = 1'b0;
            if (t1) in_valid_a[1] = 1'b0;
            n++;
        end
        if (in_valid_a[0] || in_valid_a[1]) begin
            check("in_accept_timeout", {in_valid_a[1], in_valid_a[0]}, 2'b00);
            in_valid_a[0] = 1'b0;
            in_valid_a[1] = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q[0].size() != 0 || q[1].size() != 0 || out_valid_a[0] || out_valid_a[1]) && n < 3000) begin
            tick();
            n++;
        end
        check("drain_q0", q[0].size(), 0);
        check("drain_q1", q[1].size(), 0);
    endtask

    // Scoreboard and hold-rule monitor for the two RATIO=4 instances.
    initial begin
        logic          hold [2];
        logic [OW-1:0] sv_d [2];
        logic [KW-1:0] sv_k [2];
        logic          sv_l [2];
        exp_t          e;
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int w = 0; w < 2; w++) begin
                if (!rst_n) begin
                    hold[w] = 1'b0;
                end else begin
                    if (hold[w]) begin
                        check($sformatf("hold_valid%0d", w), out_valid_a[w], 1'b1);
                        check($sformatf("hold_data%0d", w), out_data_a[w], sv_d[w]);
                        check($sformatf("hold_keep%0d", w), out_keep_a[w], sv_k[w]);
                        check($sformatf("hold_last%0d", w), out_last_a[w], sv_l[w]);
                    end
                    if (in_valid_a[w] && in_ready_a[w]) begin
                        model_push(w, in_data, in_keep, in_last);
                        exp_in[w]++;
                    end
                    if (out_valid_a[w] && out_ready_a[w]) begin
                        if (q[w].size() == 0) begin
                            check($sformatf("unexpected_out%0d", w), out_valid_a[w], 1'b0);
                        end else begin
                            e = q[w].pop_front();
                            check($sformatf("out_data%0d", w), out_data_a[w], e.d);
                            check($sformatf("out_keep%0d", w), out_keep_a[w], e.k);
                            check($sformatf("out_last%0d", w), out_last_a[w], e.l);
                        end
                        exp_out[w]++;
                    end
                    hold[w] = out_valid_a[w] && !out_ready_a[w];
                    sv_d[w] = out_data_a[w];
                    sv_k[w] = out_keep_a[w];
                    sv_l[w] = out_last_a[w];
                end
            end
        end
    end

    initial begin
        logic [IW-1:0]  d;
        logic [IKW-1:0] k;
        logic [1023:0]  a2, b2;
        logic [511:0]   e2;
        longint         t2 [4];
        longint         ta;
        int             nk, sent, nb, base_in1, base_out1, base_out0;
        logic           acc;

        rst_n = 1'b0;
        rmode = 1'b0;
        in_data = '0; in_keep = '0; in_last = 1'b0;
        in_valid_a[0] = 1'b0; in_valid_a[1] = 1'b0;
        out_ready_a[0] = 1'b1; out_ready_a[1] = 1'b1;
        in_data2 = '0; in_keep2 = '0; in_valid2 = 1'b0; in_last2 = 1'b0; out_ready2 = 1'b1;
        exp_in[0] = 0; exp_in[1] = 0; exp_out[0] = 0; exp_out[1] = 0;

        // reset state
        repeat (2) @(posedge clk);
        #2;
        check("rst_out_valid", out_valid_a[1], 1'b0);
        check("rst_out_last", out_last_a[1], 1'b0);
        check("rst_out_data", out_data_a[1], 32'h0);
        check("rst_out_keep", out_keep_a[1], 4'h0);
        check("rst_in_ready", in_ready_a[1], 1'b0);
        check("rst_stat_in", stat_in_a[1], 32'd0);
        check("rst_stat_out", stat_out_a[0], 32'd0);
        check("rst_wide_valid", out_valid2, 1'b0);
        #1 rst_n = 1'b1;
        #1 check("rel_in_ready_before_edge", in_ready_a[0], 1'b0);
        tick();
        check("rel_in_ready_after_edge", in_ready_a[0], 1'b1);
        check("rel_wide_in_ready", in_ready2, 1'b1);

        // 2:1 at 512 bits: two full beats back to back
        for (int i = 0; i < 32; i++) begin
            a2[i*32 +: 32] = $urandom();
            b2[i*32 +: 32] = $urandom();
        end
        in_data2 = a2; in_keep2 = {128{1'b1}}; in_last2 = 1'b0; in_valid2 = 1'b1;
        nk = 0; sent = 0; ta = 0;
        for (int c = 0; c < 20 && nk < 4; c++) begin
            @(negedge clk);
            acc = in_valid2 && in_ready2;
            if (acc && sent == 0) ta = $time;
            if (out_valid2) begin
                e2 = (nk < 2) ? a2[nk*512 +: 512] : b2[(nk-2)*512 +: 512];
                check("wide_data", out_data2, e2);
                check("wide_keep", out_keep2, {64{1'b1}});
                check("wide_last", out_last2, (nk == 3));
                t2[nk] = $time;
                nk++;
            end
            tick();
            if (acc) begin
                if (sent == 0) begin
                    in_data2 = b2; in_last2 = 1'b1; sent = 1;
                end else begin
                    in_valid2 = 1'b0;
                end
            end
        end
        in_valid2 = 1'b0;
        check("wide_beats", nk, 4);
        if (nk == 4) begin
            check("wide_consecutive", (t2[3] - t2[0]) / 10, 3);
            check("wide_latency", (t2[0] - ta) / 10, 1);
        end
        check("wide_stat_in", stat_in2, 32'd2);
        check("wide_stat_out", stat_out2, 32'd4);
        check("wide_idle_after", out_valid2, 1'b0);

        // sparse beat: sub-words 0 and 2 populated
        for (int i = 0; i < R; i++) d[i*OW +: OW] = $urandom();
        base_out1 = exp_out[1]; base_out0 = exp_out[0]; base_in1 = exp_in[1];
        send_beat(d, 16'h0F0F, 1'b1);
        drain();
        check("sparse_drop_beats", stat_out_a[1] - 32'(base_out1), 32'd2);
        check("sparse_keep_beats", stat_out_a[0] - 32'(base_out0), 32'd4);

        // empty beats: one mid-packet, one carrying last
        base_out1 = exp_out[1]; base_out0 = exp_out[0]; base_in1 = exp_in[1];
        send_beat(d, 16'h0000, 1'b0);
        send_beat(d, 16'h0000, 1'b1);
        drain();
        check("empty_drop_in", stat_in_a[1] - 32'(base_in1), 32'd2);
        check("empty_drop_out", stat_out_a[1] - 32'(base_out1), 32'd1);
        check("empty_keep_out", stat_out_a[0] - 32'(base_out0), 32'd8);

        // random packets with random downstream back-pressure
        rmode = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < R; i++) begin
                    d[i*OW +: OW] = $urandom();
                    case ($urandom_range(0, 3))
                        0:       k[i*KW +: KW] = 4'h0;
                        1:       k[i*KW +: KW] = 4'hF;
                        default: k[i*KW +: KW] = 4'($urandom_range(0, 15));
                    endcase
                end
                send_beat(d, k, (b == nb - 1));
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        drain();
        rmode = 1'b0;
        out_ready_a[0] = 1'b1; out_ready_a[1] = 1'b1;
        for (int w = 0; w < 2; w++) begin
            check($sformatf("rand_stat_in%0d", w), stat_in_a[w], 32'(exp_in[w]));
            check($sformatf("rand_stat_out%0d", w), stat_out_a[w], 32'(exp_out[w]));
        end

        // reset while the second sub-word is on the output
        out_ready_a[0] = 1'b0; out_ready_a[1] = 1'b0;
        for (int i = 0; i < R; i++) d[i*OW +: OW] = $urandom();
        send_beat(d, 16'hFFFF, 1'b1);
        out_ready_a[0] = 1'b1; out_ready_a[1] = 1'b1;
        tick();
        out_ready_a[0] = 1'b0; out_ready_a[1] = 1'b0;
        #1;
        check("pre_rst_data", out_data_a[1], d[OW +: OW]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid_a[1], 1'b0);
        check("mid_rst_stat_in", stat_in_a[1], 32'd0);
        check("mid_rst_stat_out", stat_out_a[0], 32'd0);
        check("mid_rst_in_ready", in_ready_a[0], 1'b0);
        q[0].delete(); q[1].delete();
        exp_in[0] = 0; exp_in[1] = 0; exp_out[0] = 0; exp_out[1] = 0;
        tick();
        #2 rst_n = 1'b1;
        tick();
        out_ready_a[0] = 1'b1; out_ready_a[1] = 1'b1;
        check("post_rst_in_ready", in_ready_a[1], 1'b1);
        for (int i = 0; i < R; i++) d[i*OW +: OW] = $urandom();
        send_beat(d, 16'hFFF0, 1'b1);
        send_beat(d, 16'hFFFF, 1'b1);
        drain();
        check("post_rst_stat_out1", stat_out_a[1], 32'd7);
        check("post_rst_stat_out0", stat_out_a[0], 32'd8);
        check("post_rst_stat_in", stat_in_a[0], 32'(exp_in[0]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
